// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and execute-stage state type.
// Used by the ALU decoder and by alu_exec_unit.
package alu_ctrl_pkg;

    localparam int ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } exec_state_t;

    function automatic logic is_mul_op(input logic [ALU_CTRL_W-1:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_exec_unit_shift_add_mult.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH iterations.
// done/product are combinational and describe the iteration happening at the coming edge.
module shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc + (mplr[0] ? mcand : '0);
    end

    // The owner registers the final value on the same edge as the last iteration.
    assign busy    = running;
    assign done    = running && (cnt == LAST_CNT);
    assign product = acc_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start && !running) begin
            acc     <= '0;
            mcand   <= a;
            mplr    <= b;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc   <= acc_next;
            mcand <= {mcand[WIDTH-2:0], 1'b0};
            mplr  <= {1'b0, mplr[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arith ops plus a multi-cycle MUL.
// Result, Zero, Busy and Done are all registered.
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [ALU_CTRL_W-1:0] ALU_Control,
    input  logic [WIDTH-1:0]      SrcA,
    input  logic [WIDTH-1:0]      SrcB,
    output logic [WIDTH-1:0]      ALU_Result,
    output logic                  Zero,
    output logic                  Busy,
    output logic                  Done
);

    exec_state_t      state;
    logic [WIDTH-1:0] simple_result;
    logic             mult_start;
    logic             mult_busy;
    logic             mult_done;
    logic [WIDTH-1:0] mult_product;

    always_comb begin
        simple_result = '0;
        case (ALU_Control)
            ALU_AND: simple_result = SrcA & SrcB;
            ALU_OR:  simple_result = SrcA | SrcB;
            ALU_ADD: simple_result = SrcA + SrcB;
            ALU_SUB: simple_result = SrcA - SrcB;
            ALU_SLT: simple_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: simple_result = '0;
        endcase
    end

    // FIN drops Busy, so a new request is accepted there just as in IDLE.
    assign mult_start = Start && is_mul_op(ALU_Control) && (state != ST_MUL);

    shift_add_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .CLK    (CLK),
        .RST    (RST),
        .start  (mult_start),
        .a      (SrcA),
        .b      (SrcB),
        .busy   (mult_busy),
        .done   (mult_done),
        .product(mult_product)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            ALU_Result <= '0;
            Zero       <= 1'b1;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    if (Start) begin
                        if (is_mul_op(ALU_Control)) begin
                            state <= ST_MUL;
                            Busy  <= 1'b1;
                        end else begin
                            ALU_Result <= simple_result;
                            Zero       <= (simple_result == '0);
                            Done       <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    Done <= 1'b0;
                    if (mult_busy && mult_done) begin
                        state      <= ST_FIN;
                        Busy       <= 1'b0;
                        Done       <= 1'b1;
                        ALU_Result <= mult_product;
                        Zero       <= (mult_product == '0);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, hand-written MUL/reset
// sequences and randomized ops against a plain-arithmetic reference model.
module tb_alu_exec_unit;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    alu_control;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [W-1:0]  alu_result;
    logic          zero;
    logic          busy;
    logic          done;

    int total_checks;
    int bad_checks;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_result;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[12];

    alu_exec_unit #(
        .WIDTH(W)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .Start      (start),
        .ALU_Control(alu_control),
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALU_Result (alu_result),
        .Zero       (zero),
        .Busy       (busy),
        .Done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] full;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b100: return a - b;
            3'b110: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'b101: begin
                full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return full[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one request for exactly one rising edge; returns on the following falling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start       = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runSimple(input string name, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        logic [W-1:0] exp;
        exp = ref_alu(op, a, b);
        applyStimulus(op, a, b);
        checkOutput({name, " done"}, W'(done), W'(1));
        checkOutput({name, " result"}, alu_result, exp);
        checkOutput({name, " zero"}, W'(zero), W'(exp == '0));
    endtask

    // Runs a MUL; when inject_at > 0 an ADD request is pulsed at that busy cycle.
    task automatic runMul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at);
        int busy_cycles;
        int early_done;
        logic [W-1:0] exp;
        exp         = ref_alu(3'b101, a, b);
        busy_cycles = 0;
        early_done  = 0;
        applyStimulus(3'b101, a, b);
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            if (done) early_done++;
            if (busy_cycles == inject_at) begin
                start       = 1'b1;
                alu_control = 3'b010;
                src_a       = 32'd100;
                src_b       = 32'd1;
            end else begin
                start       = 1'b0;
                alu_control = 3'b101;
                src_a       = $urandom;
                src_b       = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({name, " busy cycles"}, W'(busy_cycles), W'(W));
        checkOutput({name, " done during busy"}, W'(early_done), W'(0));
        checkOutput({name, " done"}, W'(done), W'(1));
        checkOutput({name, " result"}, alu_result, exp);
        checkOutput({name, " zero"}, W'(zero), W'(exp == '0));
        @(negedge clk);
        checkOutput({name, " done pulse width"}, W'(done), W'(0));
    endtask

    initial begin
        int stray_done;
        logic [2:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        total_checks = 0;
        bad_checks   = 0;
        rst          = 1'b1;
        start        = 1'b0;
        alu_control  = '0;
        src_a        = '0;
        src_b        = '0;

        vecs[0]  = '{3'b010, 32'd7, 32'd5, 32'd12, 1'b0};
        vecs[1]  = '{3'b100, 32'd5, 32'd5, 32'd0, 1'b1};
        vecs[2]  = '{3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
        vecs[3]  = '{3'b110, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1};
        vecs[4]  = '{3'b111, 32'd3, 32'd4, 32'd0, 1'b1};
        vecs[5]  = '{3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b1};
        vecs[6]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[7]  = '{3'b001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0};
        vecs[8]  = '{3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1};
        vecs[9]  = '{3'b100, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{3'b110, 32'd5, 32'd5, 32'd0, 1'b1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("reset result", alu_result, '0);
        checkOutput("reset zero", W'(zero), W'(1));
        checkOutput("reset busy", W'(busy), W'(0));
        checkOutput("reset done", W'(done), W'(0));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d done", i), W'(done), W'(1));
            checkOutput($sformatf("vec%0d result", i), alu_result, vecs[i].exp_result);
            checkOutput($sformatf("vec%0d zero", i), W'(zero), W'(vecs[i].exp_zero));
        end

        @(negedge clk);
        checkOutput("idle done low", W'(done), W'(0));
        checkOutput("result held", alu_result, 32'd1);

        // Async reset between edges while a Done pulse is showing.
        applyStimulus(3'b010, 32'd7, 32'd5);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst result", alu_result, '0);
        checkOutput("async rst zero", W'(zero), W'(1));
        checkOutput("async rst busy", W'(busy), W'(0));
        checkOutput("async rst done", W'(done), W'(0));
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back simple ops give a Done every cycle.
        @(negedge clk);
        start = 1'b1; alu_control = 3'b010; src_a = 32'd1; src_b = 32'd2;
        @(negedge clk);
        checkOutput("b2b0 done", W'(done), W'(1));
        checkOutput("b2b0 result", alu_result, 32'd3);
        alu_control = 3'b001; src_a = 32'd8; src_b = 32'd1;
        @(negedge clk);
        checkOutput("b2b1 done", W'(done), W'(1));
        checkOutput("b2b1 result", alu_result, 32'd9);
        alu_control = 3'b100; src_a = 32'd2; src_b = 32'd3;
        @(negedge clk);
        checkOutput("b2b2 done", W'(done), W'(1));
        checkOutput("b2b2 result", alu_result, 32'hFFFF_FFFF);
        start = 1'b0;
        @(negedge clk);
        checkOutput("b2b end done", W'(done), W'(0));

        runMul("mul 6x7", 32'd6, 32'd7, 0);
        runMul("mul wrap", 32'h8000_0000, 32'd2, 0);
        runMul("mul ignore start", 32'd3, 32'd9, 5);
        runMul("mul max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Reset at MUL cycle 10 aborts the multiply.
        applyStimulus(3'b101, 32'd11, 32'd13);
        repeat (9) @(negedge clk);
        checkOutput("pre-abort busy", W'(busy), W'(1));
        #1 rst = 1'b1;
        #1;
        checkOutput("abort busy", W'(busy), W'(0));
        checkOutput("abort done", W'(done), W'(0));
        checkOutput("abort result", alu_result, '0);
        checkOutput("abort zero", W'(zero), W'(1));
        @(negedge clk);
        rst = 1'b0;
        stray_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        checkOutput("abort no done", W'(stray_done), W'(0));
        runSimple("add after abort", 3'b010, 32'd1, 32'd1);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if (rop == 3'b101) begin
                runMul($sformatf("rnd%0d mul", i), ra, rb, 0);
            end else begin
                runSimple($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb);
            end
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
